// File: rtl/sar_scan_sequencer_pkg.sv
// sar_pkg: shared state encoding, SAR constants and result record for the scan sequencer
package sar_pkg;
  localparam int SAR_DATA_W = 4;
  localparam int SAR_LAT = 5;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WAIT} sar_seq_state_e;
  typedef struct packed {
    logic [2:0] ch;
    logic [SAR_DATA_W-1:0] data;
  } sar_result_t;
endpackage

// File: rtl/sar_scan_sequencer_if.sv
// sar_scan_sequencer_if: SAR-side conversion signals and result-consumer handshake
interface sar_scan_sequencer_if import sar_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = SAR_DATA_W
);
  logic [$clog2(NUM_CH)-1:0] ch_sel, res_ch;
  logic sample_sig, adc_valid, res_valid, res_ready;
  logic [DATA_W-1:0] adc_data, res_data;
  modport master(
    output ch_sel, sample_sig, res_valid, res_data, res_ch,
    input adc_valid, adc_data, res_ready
  );
  modport slave(
    input ch_sel, sample_sig, res_valid, res_data, res_ch,
    output adc_valid, adc_data, res_ready
  );
endinterface

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: synchronous result FIFO with occupancy count
module sar_result_fifo #(
  parameter int W = 6,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign do_push = push && count < CW'(DEPTH);
  assign rdata = valid ? mem[rp] : '0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer: round-robin conversion scheduler driving the SAR core
module sar_scan_sequencer import sar_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = SAR_DATA_W,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic [NUM_CH-1:0] req,
  input  logic err_clr,
  output logic busy,
  output logic err,
  output logic [$clog2(NUM_CH)-1:0] err_ch,
  sar_scan_sequencer_if.master bus
);
  localparam int CHW = $clog2(NUM_CH);
  localparam int CW = $clog2(TIMEOUT + SETTLE_CYC + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  sar_seq_state_e state, nstate;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_CH-1:0] pending;
  logic [CHW-1:0] last_grant, gnt;
  logic [FCW-1:0] fifo_cnt;
  logic [CHW+DATA_W-1:0] head;
  logic do_grant, push, tout;
  // descending scan so the channel nearest after last_grant is assigned last and wins
  always_comb begin
    gnt = last_grant;
    for (int i = NUM_CH; i >= 1; i--)
      if (pending[CHW'((int'(last_grant) + i) % NUM_CH)]) gnt = CHW'((int'(last_grant) + i) % NUM_CH);
  end
  always_comb begin
    nstate = state;
    cnt_n = cnt;
    do_grant = 1'b0;
    push = 1'b0;
    tout = 1'b0;
    unique case (state)
      IDLE: if (en && |pending && fifo_cnt < FCW'(FIFO_DEPTH)) begin
        nstate = SETTLE;
        cnt_n = '0;
        do_grant = 1'b1;
      end
      SETTLE: begin
        cnt_n = cnt + CW'(1);
        nstate = cnt == CW'(SETTLE_CYC - 1) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        nstate = WAIT;
        cnt_n = '0;
      end
      WAIT: begin
        cnt_n = cnt + CW'(1);
        push = bus.adc_valid;
        tout = !bus.adc_valid && cnt == CW'(TIMEOUT - 1);
        nstate = push || tout ? IDLE : WAIT;
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pending <= '0;
      last_grant <= CHW'(NUM_CH - 1);
      bus.ch_sel <= '0;
      err <= 1'b0;
      err_ch <= '0;
    end else begin
      state <= nstate;
      cnt <= cnt_n;
      pending <= (pending & ~(NUM_CH'(do_grant) << gnt)) | req;
      if (do_grant) begin
        last_grant <= gnt;
        bus.ch_sel <= gnt;
      end
      err <= tout || (err && !err_clr);
      if (tout) err_ch <= bus.ch_sel;
    end
  assign bus.sample_sig = rst_n && state == SAMPLE;
  assign busy = state != IDLE;
  assign {bus.res_ch, bus.res_data} = head;
  sar_result_fifo #(.W(CHW + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(bus.res_ready),
    .wdata({bus.ch_sel, bus.adc_data}),
    .rdata(head),
    .valid(bus.res_valid),
    .count(fifo_cnt)
  );
endmodule
